// File: rtl/instr_fetch_queue.sv
// Olivia fetch front end: owns the fetch PC, issues credit-limited word requests and queues {pc, instr} for decode.
// Misaligned-redirect fault handling is built in only when FETCH_ALIGN_CHECK_EN is defined.
module instr_fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [63:0] dec_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] sh_wr_q, sh_wr_d;
    logic [PW-1:0] sh_rd_q, sh_rd_d;

    logic [63:0] q_pc_q    [DEPTH];
    logic [31:0] q_instr_q [DEPTH];
    logic [63:0] sh_pc_q   [DEPTH];

    logic        req_fire_s;
    logic        rsp_acc_s;
    logic        rsp_push_s;
    logic        pop_s;
    logic        head_ok_s;
    logic        redir_fault_s;
    logic [63:0] redir_pc_s;
    logic [CW:0] credit_used_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_fault_s = (redirect_pc[1:0] != 2'b00);
    assign redir_pc_s    = redirect_pc;
    assign fetch_fault   = !rst && (state_q == ST_FAULT);
`else
    logic unused_align_s;
    assign unused_align_s = ^redirect_pc[1:0];
    assign redir_fault_s  = 1'b0;
    assign redir_pc_s     = {redirect_pc[63:2], 2'b00};
    assign fetch_fault    = 1'b0;
`endif

    // Credits cover buffered entries plus requests still out at memory, so the queue cannot overflow
    assign credit_used_s  = {1'b0, occ_q} + {1'b0, infl_q};
    assign imem_req_valid = !rst && (state_q == ST_RUN) && !redirect_valid && (credit_used_s < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire_s     = imem_req_valid && imem_req_ready;

    assign rsp_acc_s  = imem_rsp_valid && (infl_q != {CW{1'b0}});
    assign rsp_push_s = rsp_acc_s && (drop_q == {CW{1'b0}}) && !redirect_valid;

    assign head_ok_s  = !rst && (occ_q != {CW{1'b0}});
    assign dec_valid  = head_ok_s && !redirect_valid;
    assign pop_s      = dec_valid && dec_ready;
    assign dec_instr  = head_ok_s ? q_instr_q[rd_ptr_q] : 32'h0;
    assign dec_pc     = head_ok_s ? q_pc_q[rd_ptr_q] : 64'h0;

    // Next-state logic for PC, counters, pointers and the fault FSM
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        occ_d      = occ_q;
        infl_d     = infl_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sh_wr_d    = sh_wr_q;
        sh_rd_d    = sh_rd_q;

        if (req_fire_s) begin
            sh_wr_d = sh_wr_q + PW'(1);
        end else begin
            sh_wr_d = sh_wr_q;
        end

        if (rsp_acc_s) begin
            sh_rd_d = sh_rd_q + PW'(1);
        end else begin
            sh_rd_d = sh_rd_q;
        end

        if (rsp_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({req_fire_s, rsp_acc_s})
            2'b10:   infl_d = infl_q + CW'(1);
            2'b01:   infl_d = infl_q - CW'(1);
            default: infl_d = infl_q;
        endcase

        if (redirect_valid) begin
            // No request can fire here, so every response still outstanding afterwards is stale
            state_d    = redir_fault_s ? ST_FAULT : ST_RUN;
            fetch_pc_d = redir_pc_s;
            occ_d      = {CW{1'b0}};
            rd_ptr_d   = wr_ptr_q;
            drop_d     = infl_d;
        end else begin
            state_d    = state_q;
            fetch_pc_d = req_fire_s ? (fetch_pc_q + 64'd4) : fetch_pc_q;
            rd_ptr_d   = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
            case ({rsp_push_s, pop_s})
                2'b10:   occ_d = occ_q + CW'(1);
                2'b01:   occ_d = occ_q - CW'(1);
                default: occ_d = occ_q;
            endcase
            if (rsp_acc_s && (drop_q != {CW{1'b0}})) begin
                drop_d = drop_q - CW'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            occ_q      <= {CW{1'b0}};
            infl_q     <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            sh_wr_q    <= {PW{1'b0}};
            sh_rd_q    <= {PW{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            infl_q     <= infl_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sh_wr_q    <= sh_wr_d;
            sh_rd_q    <= sh_rd_d;
        end
    end

    // Payload storage: request PCs shadowed until their word returns, then paired into the queue
    always_ff @(posedge clk) begin
        if (req_fire_s) begin
            sh_pc_q[sh_wr_q] <= fetch_pc_q;
        end
        if (rsp_push_s) begin
            q_pc_q[wr_ptr_q]    <= sh_pc_q[sh_rd_q];
            q_instr_q[wr_ptr_q] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_fault;

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected fetch PC, in-flight PCs with a stale prefix, expected decode stream
    logic [63:0] m_pc;
    logic        m_fault;
    logic [63:0] infl_pc[$];
    int          stale_cnt;
    logic [63:0] exp_pc[$];
    logic [31:0] exp_instr[$];
    // Memory model: accepted addresses and the cycle their word comes back
    logic [63:0] mem_addr[$];
    int          mem_due[$];

    int    cyc, lat, nvec, errs;
    string cur;
    logic        obs_req_valid, obs_req_fire, obs_dec_valid, obs_dec_fire, obs_fault;
    logic [63:0] obs_req_addr, obs_dec_pc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic step(input logic do_rst, input logic mrdy, input logic drdy,
                        input logic rv, input logic [63:0] rpc);
        logic exp_req, exp_dec;
        @(negedge clk);
        rst            = do_rst;
        imem_req_ready = mrdy;
        dec_ready      = drdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (!do_rst && mem_due.size() > 0 && mem_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_req_fire  = imem_req_valid && mrdy;
        obs_dec_valid = dec_valid;
        obs_dec_pc    = dec_pc;
        obs_dec_fire  = dec_valid && drdy;
        obs_fault     = fetch_fault;
        if (do_rst) begin
            nvec++;
            if ({imem_req_valid, dec_valid, fetch_fault} !== 3'b000 || dec_instr !== 32'h0 || dec_pc !== 64'h0) begin
                errs++;
                $display("FAIL %s reset_outputs: got req=%b dec=%b flt=%b instr=%h pc=%h, want all zero",
                         cur, imem_req_valid, dec_valid, fetch_fault, dec_instr, dec_pc);
            end
            mem_addr.delete(); mem_due.delete(); infl_pc.delete();
            exp_pc.delete(); exp_instr.delete();
            stale_cnt = 0; m_pc = RESET_PC; m_fault = 1'b0;
        end else begin
            exp_req = !m_fault && !rv && ((exp_pc.size() + infl_pc.size()) < DEPTH);
            exp_dec = (exp_pc.size() > 0) && !rv;
            nvec++;
            if (imem_req_valid !== exp_req) begin
                errs++;
                $display("FAIL %s req_valid: got %b want %b (cyc %0d)", cur, imem_req_valid, exp_req, cyc);
            end
            nvec++;
            if (dec_valid !== exp_dec) begin
                errs++;
                $display("FAIL %s dec_valid: got %b want %b (cyc %0d)", cur, dec_valid, exp_dec, cyc);
            end
            nvec++;
            if (fetch_fault !== m_fault) begin
                errs++;
                $display("FAIL %s fetch_fault: got %b want %b (cyc %0d)", cur, fetch_fault, m_fault, cyc);
            end
            if (exp_req) begin
                nvec++;
                if (imem_req_addr !== m_pc) begin
                    errs++;
                    $display("FAIL %s req_addr: got %h want %h (cyc %0d)", cur, imem_req_addr, m_pc, cyc);
                end
            end
            if (exp_dec) begin
                nvec++;
                if (dec_pc !== exp_pc[0] || dec_instr !== exp_instr[0]) begin
                    errs++;
                    $display("FAIL %s dec_head: got pc=%h instr=%h want pc=%h instr=%h (cyc %0d)",
                             cur, dec_pc, dec_instr, exp_pc[0], exp_instr[0], cyc);
                end
            end
            if (exp_dec && drdy) begin
                void'(exp_pc.pop_front());
                void'(exp_instr.pop_front());
            end
            if (imem_rsp_valid) begin
                void'(mem_addr.pop_front());
                void'(mem_due.pop_front());
                if (infl_pc.size() > 0) begin
                    if (stale_cnt > 0) begin
                        stale_cnt--;
                        void'(infl_pc.pop_front());
                    end else if (!rv) begin
                        exp_pc.push_back(infl_pc[0]);
                        exp_instr.push_back(mem_word(infl_pc[0]));
                        void'(infl_pc.pop_front());
                    end else begin
                        void'(infl_pc.pop_front());
                    end
                end
            end
            if (obs_req_fire) begin
                mem_addr.push_back(imem_req_addr);
                mem_due.push_back(cyc + lat);
                infl_pc.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
            if (rv) begin
                stale_cnt = infl_pc.size();
                exp_pc.delete(); exp_instr.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                m_fault = (rpc[1:0] != 2'b00);
                m_pc    = rpc;
`else
                m_pc    = {rpc[63:2], 2'b00};
`endif
            end
        end
        cyc++;
    endtask

    task automatic reset_dut(input int l);
        lat = l;
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_reset();
        cur = "reset";
        reset_dut(1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        nvec++;
        if (obs_req_valid !== 1'b1 || obs_req_addr !== RESET_PC) begin
            errs++;
            $display("FAIL %s first_req: got valid=%b addr=%h want valid=1 addr=%h", cur, obs_req_valid, obs_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int first, n;
        logic [63:0] e_pc;
        cur = "stream"; first = -1; n = 0; e_pc = 64'h0;
        reset_dut(1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
            if (obs_dec_fire) begin
                if (first < 0) first = i;
                nvec++;
                if (obs_dec_pc !== e_pc) begin
                    errs++;
                    $display("FAIL %s seq_pc: got %h want %h", cur, obs_dec_pc, e_pc);
                end
                e_pc = e_pc + 64'd4;
                n++;
            end
        end
        nvec++;
        if (first !== 2) begin errs++; $display("FAIL %s first_dec_cycle: got %0d want 2", cur, first); end
        nvec++;
        if (n !== 18) begin errs++; $display("FAIL %s dec_count: got %0d want 18", cur, n); end
    endtask

    task automatic test_backpressure();
        int reqs, got;
        logic [63:0] e_pc;
        cur = "backpressure"; reqs = 0; got = 0; e_pc = 64'h0;
        reset_dut(1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
            if (obs_req_fire) reqs++;
        end
        nvec++;
        if (reqs !== DEPTH) begin errs++; $display("FAIL %s req_count: got %0d want %0d", cur, reqs, DEPTH); end
        nvec++;
        if (obs_req_valid !== 1'b0) begin errs++; $display("FAIL %s stalled_req_valid: got %b want 0", cur, obs_req_valid); end
        for (int i = 0; i < 12 && got < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
            if (obs_dec_fire) begin
                nvec++;
                if (obs_dec_pc !== e_pc) begin errs++; $display("FAIL %s drain_pc: got %h want %h", cur, obs_dec_pc, e_pc); end
                e_pc = e_pc + 64'd4;
                got++;
            end
        end
        nvec++;
        if (got !== 4) begin errs++; $display("FAIL %s drain_count: got %0d want 4", cur, got); end
    endtask

    task automatic test_redirect_stale();
        logic found;
        cur = "redirect_stale"; found = 1'b0;
        reset_dut(3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 64'h1000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        nvec++;
        if (obs_req_addr !== 64'h1000) begin errs++; $display("FAIL %s req_after_redirect: got %h want 1000", cur, obs_req_addr); end
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
            if (obs_dec_fire) begin
                found = 1'b1;
                nvec++;
                if (obs_dec_pc !== 64'h1000) begin errs++; $display("FAIL %s first_pc: got %h want 1000", cur, obs_dec_pc); end
            end
        end
        nvec++;
        if (!found) begin errs++; $display("FAIL %s timeout: got no decode want pc 1000", cur); end
    endtask

    task automatic test_redirect_collide();
        int reqs;
        logic found;
        cur = "redirect_collide"; reqs = 0; found = 1'b0;
        reset_dut(1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 64'h2000);
        nvec++;
        if (obs_dec_valid !== 1'b0) begin errs++; $display("FAIL %s dec_in_redirect: got %b want 0", cur, obs_dec_valid); end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
            if (i == 0) begin
                nvec++;
                if (obs_dec_valid !== 1'b0) begin errs++; $display("FAIL %s dec_after_redirect: got %b want 0", cur, obs_dec_valid); end
            end
            if (obs_req_fire) reqs++;
        end
        nvec++;
        if (reqs !== DEPTH) begin errs++; $display("FAIL %s credits: got %0d want %0d", cur, reqs, DEPTH); end
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
            if (obs_dec_fire) begin
                found = 1'b1;
                nvec++;
                if (obs_dec_pc !== 64'h2000) begin errs++; $display("FAIL %s first_pc: got %h want 2000", cur, obs_dec_pc); end
            end
        end
        nvec++;
        if (!found) begin errs++; $display("FAIL %s timeout: got no decode want pc 2000", cur); end
    endtask

    task automatic test_wrap();
        int n;
        cur = "wrap"; n = 0;
        reset_dut(1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 10 && n < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
            if (obs_req_fire) begin
                nvec++;
                if (n == 0 && obs_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
                    errs++; $display("FAIL %s top_addr: got %h want fffffffffffffffc", cur, obs_req_addr);
                end else if (n == 1 && obs_req_addr !== 64'h0) begin
                    errs++; $display("FAIL %s wrapped_addr: got %h want 0", cur, obs_req_addr);
                end
                n++;
            end
        end
        nvec++;
        if (n !== 2) begin errs++; $display("FAIL %s timeout: got %0d requests want 2", cur, n); end
    endtask

    task automatic test_align();
        cur = "align";
        reset_dut(2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 64'h1002);
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        begin
            int reqs;
            logic found;
            reqs = 0; found = 1'b0;
            nvec++;
            if (obs_fault !== 1'b1 || obs_req_valid !== 1'b0) begin
                errs++; $display("FAIL %s fault_set: got fault=%b req=%b want fault=1 req=0", cur, obs_fault, obs_req_valid);
            end
            for (int i = 0; i < 8; i++) begin
                step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
                if (obs_req_fire) reqs++;
            end
            nvec++;
            if (reqs !== 0 || obs_fault !== 1'b1) begin
                errs++; $display("FAIL %s fault_hold: got reqs=%0d fault=%b want reqs=0 fault=1", cur, reqs, obs_fault);
            end
            step(1'b0, 1'b1, 1'b1, 1'b1, 64'h2000);
            step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
            nvec++;
            if (obs_fault !== 1'b0 || obs_req_valid !== 1'b1 || obs_req_addr !== 64'h2000) begin
                errs++; $display("FAIL %s fault_clear: got fault=%b req=%b addr=%h want 0 1 2000", cur, obs_fault, obs_req_valid, obs_req_addr);
            end
            for (int i = 0; i < 10 && !found; i++) begin
                step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
                if (obs_dec_fire) begin
                    found = 1'b1;
                    nvec++;
                    if (obs_dec_pc !== 64'h2000) begin errs++; $display("FAIL %s resume_pc: got %h want 2000", cur, obs_dec_pc); end
                end
            end
            nvec++;
            if (!found) begin errs++; $display("FAIL %s timeout: got no decode want pc 2000", cur); end
        end
`else
        nvec++;
        if (obs_fault !== 1'b0 || obs_req_valid !== 1'b1 || obs_req_addr !== 64'h1000) begin
            errs++; $display("FAIL %s forced_align: got fault=%b req=%b addr=%h want 0 1 1000", cur, obs_fault, obs_req_valid, obs_req_addr);
        end
`endif
    endtask

    task automatic test_random();
        logic [63:0] rpc;
        logic rs, rv, mr, dr;
        cur = "random";
        for (int run = 0; run < 4; run++) begin
            reset_dut(int'($urandom_range(1, 4)));
            for (int i = 0; i < 250; i++) begin
                rs  = ($urandom_range(0, 149) == 0);
                rv  = !rs && ($urandom_range(0, 14) == 0);
                mr  = ($urandom_range(0, 3) != 0);
                dr  = ($urandom_range(0, 3) != 0);
                rpc = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
                step(rs, mr, dr, rv, rpc);
            end
        end
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
        nvec = 0; errs = 0; cyc = 0; lat = 1; stale_cnt = 0; m_pc = RESET_PC; m_fault = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collide();
        test_wrap();
        test_align();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
